// File: rtl/sample_player_pkg.sv
// Shared types and sizing helpers for the sample playback source.
package sample_player_pkg;

  localparam int DEF_W = 16;
  localparam int DEF_N = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  // Address width for a RAM of the given depth; never narrower than one bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sample_player_if.sv
// Valid/ready frame stream carrying N channels of W bits from the player.
interface sample_player_if
  import sample_player_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int N = DEF_N
);

  logic [N*W-1:0] tdata;
  logic           tvalid;
  logic           tready;
  logic           tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/sample_ram.sv
// Simple dual-port frame RAM, one lane per channel, read-first registered read.
module sample_ram
  import sample_player_pkg::*;
#(
  parameter int LANE_W = DEF_W,
  parameter int LANES  = DEF_N,
  parameter int D      = 4096,
  localparam int AW    = addr_width(D)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [LANES*LANE_W-1:0] wr_data,
  input  logic                    rd_en,
  input  logic [AW-1:0]           rd_addr,
  output logic [LANES*LANE_W-1:0] rd_data
);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [LANE_W-1:0] mem [D];
      logic [LANE_W-1:0] rd_data_reg;

      always_ff @(posedge clk) begin
        if (wr_en) begin
          mem[wr_addr] <= wr_data[gi*LANE_W +: LANE_W];
        end
      end

      // Old contents win on a same-address read/write; the output register
      // is the only resettable part so the array still maps onto block RAM.
      always_ff @(posedge clk) begin
        if (reset) begin
          rd_data_reg <= '0;
        end else if (rd_en) begin
          rd_data_reg <= mem[rd_addr];
        end
      end

      assign rd_data[gi*LANE_W +: LANE_W] = rd_data_reg;
    end
  endgenerate

endmodule

// File: rtl/sample_player.sv
// Streams frames from an on-chip RAM at clk/(rate_div+1), one-shot or looped,
// holding frames under backpressure and counting ticks lost to it.
module sample_player
  import sample_player_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int N     = DEF_N,
  parameter int D     = 4096,
  parameter int DIV_W = 16,
  parameter int OVR_W = 16,
  localparam int AW   = addr_width(D)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [N*W-1:0]       wr_data,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 loop_en,
  input  logic [AW-1:0]        length,
  input  logic [DIV_W-1:0]     rate_div,
  sample_player_if.master      m,
  output logic                 busy,
  output logic                 done,
  output logic [OVR_W-1:0]     overrun_cnt
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(D - 1);

  state_t           state_reg, state_next;
  logic [AW-1:0]    addr_reg, addr_next;
  logic [AW-1:0]    len_reg, len_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [DIV_W-1:0] rate_reg, rate_next;
  logic             loop_reg, loop_next;
  logic [OVR_W-1:0] ovr_reg, ovr_next;
  logic             tvalid_reg, tvalid_next;
  logic             tlast_reg, tlast_next;
  logic             done_reg, done_next;

  logic             tick;
  logic             slot_free;
  logic             rd_en;
  logic             at_end;
  logic [N*W-1:0]   rd_data;

  assign tick      = (state_reg == RUN) && (div_reg == rate_reg);
  assign slot_free = !tvalid_reg || m.tready;
  assign rd_en     = tick && slot_free;
  assign at_end    = (addr_reg == len_reg);

  sample_ram #(
    .LANE_W (W),
    .LANES  (N),
    .D      (D)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (addr_reg),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      len_reg    <= '0;
      div_reg    <= '0;
      rate_reg   <= '0;
      loop_reg   <= 1'b0;
      ovr_reg    <= '0;
      tvalid_reg <= 1'b0;
      tlast_reg  <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      len_reg    <= len_next;
      div_reg    <= div_next;
      rate_reg   <= rate_next;
      loop_reg   <= loop_next;
      ovr_reg    <= ovr_next;
      tvalid_reg <= tvalid_next;
      tlast_reg  <= tlast_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    len_next    = len_reg;
    div_next    = div_reg;
    rate_next   = rate_reg;
    loop_next   = loop_reg;
    ovr_next    = ovr_reg;
    tvalid_next = tvalid_reg && !m.tready;
    tlast_next  = tlast_reg;
    done_next   = 1'b0;

    // The RAM output register doubles as the frame register, so a read
    // issued now is the frame presented next cycle.
    if (rd_en) begin
      tvalid_next = 1'b1;
      tlast_next  = at_end;
    end

    case (state_reg)
      IDLE: begin
        if (start && !stop) begin
          len_next   = (length > LAST_ADDR) ? LAST_ADDR : length;
          loop_next  = loop_en;
          rate_next  = rate_div;
          div_next   = '0;
          addr_next  = '0;
          ovr_next   = '0;
          state_next = RUN;
        end
      end

      RUN: begin
        div_next = tick ? '0 : div_reg + 1'b1;
        if (tick && !slot_free && (ovr_reg != '1)) begin
          ovr_next = ovr_reg + 1'b1;
        end
        if (rd_en) begin
          if (at_end) begin
            addr_next = '0;
            if (!loop_reg) begin
              state_next = FLUSH;
            end
          end else begin
            addr_next = addr_reg + 1'b1;
          end
        end
        // A read issued alongside stop still lands and is drained in FLUSH.
        if (stop) begin
          state_next = FLUSH;
        end
      end

      FLUSH: begin
        if (slot_free) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign m.tdata     = rd_data;
  assign m.tvalid    = tvalid_reg;
  assign m.tlast     = tlast_reg;
  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;
  assign overrun_cnt = ovr_reg;

endmodule

// File: tb/tb_sample_player.sv
// Directed scoreboard bench for sample_player; a second instance with a
// 4-bit overrun counter covers saturation.
module tb_sample_player;
  import sample_player_pkg::*;

  localparam int W  = 16;
  localparam int N  = 2;
  localparam int D  = 4096;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic           wr_en = 1'b0;
  logic [AW-1:0]  wr_addr = '0;
  logic [N*W-1:0] wr_data = '0;
  logic           start = 1'b0;
  logic           stop = 1'b0;
  logic           loop_en = 1'b0;
  logic [AW-1:0]  length = '0;
  logic [15:0]    rate_div = '0;
  logic           busy, done;
  logic [15:0]    overrun_cnt;
  logic           busy2, done2;
  logic [3:0]     overrun2;

  sample_player_if #(.W(W), .N(N)) s_if ();
  sample_player_if #(.W(W), .N(N)) s2_if ();

  sample_player #(.W(W), .N(N), .D(D), .DIV_W(16), .OVR_W(16)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .loop_en(loop_en), .length(length), .rate_div(rate_div),
    .m(s_if), .busy(busy), .done(done), .overrun_cnt(overrun_cnt)
  );

  sample_player #(.W(W), .N(N), .D(16), .DIV_W(16), .OVR_W(4)) dut2 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr[3:0]), .wr_data(wr_data),
    .start(start), .stop(stop), .loop_en(loop_en), .length(length[3:0]), .rate_div(rate_div),
    .m(s2_if), .busy(busy2), .done(done2), .overrun_cnt(overrun2)
  );

  typedef struct packed {
    logic [N*W-1:0] data;
    logic           last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   got = 0;
  int   last_hs = -1;
  int   gap_chk = 0;

  function automatic logic [N*W-1:0] frame(input int k);
    return {16'(k), 16'(16'h1000 + k)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_seq(input int count, input int len);
    exp_t e;
    for (int i = 0; i < count; i++) begin
      e.data = frame(i % (len + 1));
      e.last = ((i % (len + 1)) == len);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_one(input logic [N*W-1:0] data, input logic last);
    exp_t e;
    e.data = data;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic write_frame(input int addr, input logic [N*W-1:0] data);
    wr_en = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input int len, input int rate, input logic lp);
    length = AW'(len);
    rate_div = 16'(rate);
    loop_en = lp;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Compare the frame being handed over at the coming edge, if any.
  task automatic see_frame();
    exp_t e;
    if (s_if.tvalid && s_if.tready) begin
      $display("frame t=%0d tdata=%h tlast=%b", cyc, s_if.tdata, s_if.tlast);
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL extra_frame observed=%h expected=none", s_if.tdata);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("tdata", s_if.tdata, e.data);
        check("tlast", s_if.tlast, e.last);
        if (gap_chk != 0 && last_hs >= 0) check("tick_gap", cyc - last_hs, gap_chk);
      end
      last_hs = cyc;
      got++;
    end
  endtask

  task automatic collect(input int n, input int gap, input int budget);
    int t;
    t = 0;
    got = 0;
    last_hs = -1;
    gap_chk = gap;
    while (got < n && t < budget) begin
      see_frame();
      @(negedge clk);
      t++;
    end
    check("collect_count", got, n);
  endtask

  task automatic wait_done(input int budget, output int waited);
    int  t;
    logic seen;
    t = 0;
    seen = 1'b0;
    gap_chk = 0;
    while (!seen && t < budget) begin
      see_frame();
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        t++;
      end
    end
    check("done_seen", seen, 1);
    check("queue_empty", exp_q.size(), 0);
    waited = t;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    int t;
    s_if.tready = 1'b1;
    s2_if.tready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tvalid", s_if.tvalid, 0);
    check("rst_tlast", s_if.tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovr", overrun_cnt, 0);
    check("rst_tdata", s_if.tdata, 0);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) write_frame(k, frame(k));

    // One-shot, 8 frames four clocks apart.
    push_seq(8, 7);
    pulse_start(7, 3, 1'b0);
    collect(8, 4, 100);
    wait_done(20, waited);
    check("t1_done_latency", waited, 0);
    check("t1_busy", busy, 0);
    @(negedge clk);
    check("t1_done_pulse", done, 0);

    // Looped, 20 frames, then stop.
    push_seq(20, 7);
    pulse_start(7, 3, 1'b1);
    collect(20, 4, 200);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done(20, waited);
    check("t2_ovr", overrun_cnt, 0);

    // Backpressure for 10 ticks at full rate.
    s_if.tready = 1'b0;
    push_seq(8, 7);
    pulse_start(7, 0, 1'b0);
    t = 0;
    while (!s_if.tvalid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("t3_first_valid", s_if.tvalid, 1);
    repeat (10) @(negedge clk);
    check("t3_hold_valid", s_if.tvalid, 1);
    check("t3_hold_data", s_if.tdata, frame(0));
    check("t3_ovr", overrun_cnt, 10);
    s_if.tready = 1'b1;
    collect(8, 1, 50);
    wait_done(20, waited);
    check("t3_ovr_after", overrun_cnt, 10);

    // Saturation: 20 skipped ticks on both instances.
    s_if.tready = 1'b0;
    s2_if.tready = 1'b0;
    pulse_start(7, 0, 1'b1);
    t = 0;
    while (!s_if.tvalid && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat (20) @(negedge clk);
    check("t4_ovr16", overrun_cnt, 20);
    check("t4_ovr4_sat", overrun2, 15);
    push_one(frame(0), 1'b0);
    push_one(frame(1), 1'b0);
    s_if.tready = 1'b1;
    s2_if.tready = 1'b1;
    stop = 1'b1;
    gap_chk = 0;
    see_frame();
    @(negedge clk);
    stop = 1'b0;
    wait_done(20, waited);

    // Reset mid-stream, then replay from frame 0.
    s2_if.tready = 1'b0;
    push_seq(5, 7);
    pulse_start(7, 1, 1'b0);
    collect(5, 2, 100);
    check("t5_pre_ovr2_nonzero", (overrun2 != 0), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_tvalid", s_if.tvalid, 0);
    check("t5_busy", busy, 0);
    check("t5_ovr", overrun_cnt, 0);
    check("t5_ovr2", overrun2, 0);
    check("t5_tdata", s_if.tdata, 0);
    s2_if.tready = 1'b1;
    push_seq(8, 7);
    pulse_start(7, 1, 1'b0);
    collect(8, 2, 100);
    wait_done(20, waited);

    // start and stop together stay idle.
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t6_ss_busy", busy, 0);
      check("t6_ss_tvalid", s_if.tvalid, 0);
      @(negedge clk);
    end

    // start while busy is ignored.
    push_seq(8, 7);
    pulse_start(7, 3, 1'b0);
    collect(3, 4, 100);
    length = AW'(2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    length = AW'(7);
    collect(5, 4, 100);
    wait_done(20, waited);

    // length=0 loops a single frame with tlast set.
    for (int i = 0; i < 5; i++) push_one(frame(0), 1'b1);
    pulse_start(0, 1, 1'b1);
    collect(4, 2, 100);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done(20, waited);

    // Same-cycle write to the address being read returns old data.
    push_one(frame(0), 1'b1);
    length = '0;
    rate_div = '0;
    loop_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b1;
    wr_addr = '0;
    wr_data = 32'hCAFE_5A5A;
    @(negedge clk);
    wr_en = 1'b0;
    wait_done(10, waited);
    push_one(32'hCAFE_5A5A, 1'b1);
    pulse_start(0, 0, 1'b0);
    collect(1, 0, 20);
    wait_done(10, waited);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
